hiscore_ioctl_host: RTL and testbench

//  Initiator side of the HPS ioctl byte-stream protocol used by hiscore: drives download/upload sessions into
//  a core-side responder. Sequences config (index 3) and dump (index 4) downloads from a byte source, and dump

---
 rtl/hiscore_host_pkg.sv | 24 ++
 rtl/hs_host_timer.sv | 27 ++
 rtl/hiscore_ioctl_host.sv | 181 ++++++++++++++++++
 tb/tb_hiscore_ioctl_host.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_host_pkg.sv
// Shared types and constants for the hiscore ioctl initiator.
package hiscore_host_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_SRCWAIT,
        S_WRITE,
        S_GAP,
        S_UPADDR,
        S_UPWAIT,
        S_CAPTURE,
        S_TAIL,
        S_DONE
    } host_state_t;

    localparam logic OP_DOWNLOAD = 1'b0;
    localparam logic OP_UPLOAD   = 1'b1;

    localparam logic [7:0] HS_IDX_CONFIG = 8'd3;
    localparam logic [7:0] HS_IDX_DUMP   = 8'd4;

endpackage

// File: rtl/hs_host_timer.sv
// Loadable down-counter that saturates at zero; paces source latency, write gaps and read waits.
module hs_host_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hiscore_ioctl_host.sv
// Initiator for the hiscore ioctl byte stream: replays a byte source as a download or saves an upload into a sink.
// Optional HS_HOST_CHECKSUM_EN adds a mod-256 sum of every byte strobed in the session.
module hiscore_ioctl_host
    import hiscore_host_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int WR_GAP      = 3,
    parameter int RD_WAIT     = 4,
    parameter int SRC_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [7:0]        cmd_index,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              cmd_abort,
    output logic              done,
    output logic              aborted,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic              sink_we,
    output logic [ADDR_W-1:0] sink_addr,
    output logic [7:0]        sink_data,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic [7:0]        ioctl_din,
    output logic [7:0]        xfer_sum
);

    // Timer reload values are one less than the wait length; the read wait also counts the UPADDR cycle.
    localparam logic [7:0] SRC_LOAD = 8'(SRC_LATENCY - 1);
    localparam logic [7:0] GAP_LOAD = 8'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic [7:0] RD_LOAD  = 8'((RD_WAIT > 1) ? RD_WAIT - 2 : 0);

    host_state_t       state_q, state_d;
    logic              op_q;
    logic [7:0]        index_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;
    logic              abort_q;
    logic              tmr_load;
    logic [7:0]        tmr_val;
    logic              tmr_zero;
    logic              accept;
    logic              last_byte;
    logic              abort_any;
    logic              src_take;

    hs_host_timer #(.W(8)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign last_byte = (addr_q == len_q - ADDR_W'(1));
    assign abort_any = abort_q || cmd_abort;
    assign src_take  = (state_q == S_SRCWAIT) && tmr_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_DOWNLOAD;
            index_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= cmd_op;
                index_q <= cmd_index;
                len_q   <= cmd_len;
                addr_q  <= '0;
                abort_q <= 1'b0;
            end else begin
                if (state_q != S_IDLE && cmd_abort) abort_q <= 1'b1;
                if (state_q == S_WRITE || state_q == S_CAPTURE) addr_q <= addr_q + ADDR_W'(1);
                if (src_take) dout_q <= src_data;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch of the case leaves a signal unassigned and infers a latch.
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = S_SETUP;
            S_SETUP: begin
                if (len_q == '0 || abort_any) state_d = S_TAIL;
                else if (op_q == OP_UPLOAD)   state_d = S_UPADDR;
                else                          state_d = S_FETCH;
            end
            S_FETCH: begin
                tmr_load = 1'b1;
                tmr_val  = SRC_LOAD;
                state_d  = S_SRCWAIT;
            end
            S_SRCWAIT: if (tmr_zero) state_d = S_WRITE;
            S_WRITE: begin
                if (last_byte || abort_any) begin
                    state_d = S_TAIL;
                end else if (WR_GAP == 0) begin
                    state_d = S_FETCH;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_any)     state_d = S_TAIL;
                else if (tmr_zero) state_d = S_FETCH;
            end
            S_UPADDR: begin
                if (RD_WAIT <= 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = RD_LOAD;
                    state_d  = S_UPWAIT;
                end
            end
            S_UPWAIT:  if (tmr_zero) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (last_byte || abort_any) ? S_TAIL : S_UPADDR;
            S_TAIL:    state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Session strobes decode straight from state so an async reset drops them without waiting for a clock.
    assign cmd_ready      = (state_q == S_IDLE) && !reset;
    assign ioctl_download = (state_q != S_IDLE) && (state_q != S_DONE) && (op_q == OP_DOWNLOAD);
    assign ioctl_upload   = (state_q != S_IDLE) && (state_q != S_DONE) && (op_q == OP_UPLOAD);
    assign ioctl_wr       = (state_q == S_WRITE);
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = src_take ? src_data : dout_q;
    assign ioctl_index    = index_q;
    assign src_rd         = (state_q == S_FETCH);
    assign src_addr       = addr_q;
    assign sink_we        = (state_q == S_CAPTURE);
    assign sink_addr      = addr_q;
    assign sink_data      = sink_we ? ioctl_din : 8'h00;
    assign done           = (state_q == S_DONE);
    assign aborted        = (state_q == S_DONE) && abort_q;

`ifdef HS_HOST_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state_q == S_WRITE) begin
            sum_q <= sum_q + dout_q;
        end else if (state_q == S_CAPTURE) begin
            sum_q <= sum_q + ioctl_din;
        end
    end

    assign xfer_sum = sum_q;
`else
    assign xfer_sum = 8'h00;
`endif

endmodule

// File: tb/tb_hiscore_ioctl_host.sv
// Directed bench for hiscore_ioctl_host: download, upload, zero length, abort, async reset, checksum.
module tb_hiscore_ioctl_host;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_op = 1'b0;
    logic [7:0]        cmd_index = '0;
    logic [ADDR_W-1:0] cmd_len = '0;
    logic              cmd_abort = 1'b0;
    logic              done, aborted;
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_data = '0;
    logic              sink_we;
    logic [ADDR_W-1:0] sink_addr;
    logic [7:0]        sink_data;
    logic              ioctl_download, ioctl_upload, ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout, ioctl_index, ioctl_din, xfer_sum;

    hiscore_ioctl_host #(.ADDR_W(ADDR_W), .WR_GAP(3), .RD_WAIT(4), .SRC_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_index(cmd_index),
        .cmd_len(cmd_len), .cmd_abort(cmd_abort), .done(done), .aborted(aborted),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .sink_we(sink_we), .sink_addr(sink_addr), .sink_data(sink_data),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_din(ioctl_din), .xfer_sum(xfer_sum)
    );

    always #5 clk = ~clk;

    // Byte source with one cycle of read latency; responder returns the inverted address.
    logic [7:0] src_mem [256];
    always @(posedge clk) if (src_rd) src_data <= src_mem[src_addr[7:0]];
    assign ioctl_din = ~ioctl_addr[7:0];

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor state, sampled on the falling edge.
    int         cyc = 0;
    int         wr_n, we_n, done_n, dl_n, up_n, dl_last, done_cyc, stable_bad, age_bad, age;
    logic       last_aborted;
    logic [31:0] wr_addr [64];
    logic [7:0]  wr_dout [64];
    int          wr_cyc  [64];
    logic [7:0]  sink_mem [256];
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [7:0]        prev_dout = '0;

    always @(negedge clk) begin
        cyc++;
        if (ioctl_addr != prev_addr) age = 0;
        else                         age++;
        if (ioctl_wr) begin
            if (ioctl_addr != prev_addr || ioctl_dout != prev_dout) stable_bad++;
            if (wr_n < 64) begin
                wr_addr[wr_n] = 32'(ioctl_addr);
                wr_dout[wr_n] = ioctl_dout;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (sink_we) begin
            if (we_n == 0 ? (age < 4) : (age != 4)) age_bad++;
            sink_mem[sink_addr[7:0]] = sink_data;
            we_n++;
        end
        if (ioctl_download) begin dl_n++; dl_last = cyc; end
        if (ioctl_upload) up_n++;
        if (done) begin done_n++; done_cyc = cyc; last_aborted = aborted; end
        prev_addr = ioctl_addr;
        prev_dout = ioctl_dout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_n = 0; we_n = 0; done_n = 0; dl_n = 0; up_n = 0; dl_last = 0; done_cyc = 0;
        stable_bad = 0; age_bad = 0; last_aborted = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic op, input logic [7:0] idx, input int len);
        clear_mon();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_index = idx;
        cmd_len   = ADDR_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check(tag, 32'(done_n), 32'd1);
    endtask

    initial begin
        int bad;
        int k;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'(i);
        for (int i = 0; i < 256; i++) sink_mem[i] = 8'h00;
        clear_mon();
        age = 0;

        // Reset state
        repeat (3) tick();
        check("rst cmd_ready low in reset", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst download/upload/wr", {29'd0, ioctl_download, ioctl_upload, ioctl_wr}, 32'd0);
        check("rst done/index/sum", {15'd0, done, ioctl_index, xfer_sum}, 32'd0);

        // 1: download idx 3, 16-byte ramp; a second command while busy is ignored
        start_cmd(1'b0, 8'd3, 16);
        repeat (3) tick();
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_index = 8'd9; cmd_len = ADDR_W'(5);
        check("t1 busy cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        wait_done("t1 done count", 500);
        check("t1 wr count", 32'(wr_n), 32'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (wr_addr[i] != 32'(i) || wr_dout[i] != 8'(i)) bad++;
        check("t1 addr/dout ramp", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < 16; i++) if (wr_cyc[i] - wr_cyc[i-1] != 6) bad++;
        check("t1 wr pitch", 32'(bad), 32'd0);
        check("t1 addr/dout stable", 32'(stable_bad), 32'd0);
        check("t1 aborted", 32'(last_aborted), 32'd0);
        repeat (10) tick();
        check("t1 no second session", {16'd0, 8'(up_n), ioctl_index}, 32'h0000_0003);
`ifdef HS_HOST_CHECKSUM_EN
        check("t1 xfer_sum", 32'(xfer_sum), 32'h78);
`else
        check("t1 xfer_sum", 32'(xfer_sum), 32'h00);
`endif

        // 2: upload idx 4, 8 bytes of inverted address
        start_cmd(1'b1, 8'd4, 8);
        wait_done("t2 done count", 500);
        check("t2 sink_we count", 32'(we_n), 32'd8);
        check("t2 sink bytes", {sink_mem[0], sink_mem[3], sink_mem[5], sink_mem[7]}, 32'hFFFC_FAF8);
        check("t2 read wait", 32'(age_bad), 32'd0);
        check("t2 no wr / index", {16'd0, 8'(wr_n), ioctl_index}, 32'h0000_0004);
`ifdef HS_HOST_CHECKSUM_EN
        check("t2 xfer_sum", 32'(xfer_sum), 32'hDC);
`else
        check("t2 xfer_sum", 32'(xfer_sum), 32'h00);
`endif

        // 4: abort during byte 5 of a 64-byte download
        start_cmd(1'b0, 8'd3, 64);
        k = 0;
        while (!(ioctl_wr && ioctl_addr == ADDR_W'(5)) && k < 400) begin
            tick();
            k++;
        end
        check("t4 reached byte 5", 32'(ioctl_wr), 32'd1);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done("t4 done count", 100);
        check("t4 wr count", 32'(wr_n), 32'd6);
        check("t4 last wr addr", wr_addr[5], 32'd5);
        check("t4 aborted", 32'(last_aborted), 32'd1);
        check("t4 download low", 32'(ioctl_download), 32'd0);

        // 3: abort in idle is ignored, then zero-length download
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        start_cmd(1'b0, 8'd3, 0);
        wait_done("t3 done count", 50);
        check("t3 download cycles", 32'(dl_n), 32'd2);
        check("t3 done after download", 32'(done_cyc - dl_last), 32'd1);
        check("t3 no wr, not aborted", {31'd0, last_aborted} | 32'(wr_n << 1), 32'd0);

        // 5: async reset in the middle of an upload
        start_cmd(1'b1, 8'd4, 8);
        k = 0;
        while (!(sink_we && we_n >= 2) && k < 300) begin
            tick();
            k++;
        end
        check("t5 mid-upload", 32'(sink_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5 strobes drop at once", {28'd0, ioctl_upload, ioctl_download, sink_we, cmd_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t5 ready after reset", 32'(cmd_ready), 32'd1);

        // 6: download 01,02,FF after the reset
        src_mem[0] = 8'h01; src_mem[1] = 8'h02; src_mem[2] = 8'hFF;
        start_cmd(1'b0, 8'd3, 3);
        wait_done("t6 done count", 100);
        check("t6 bytes", {8'(wr_n), wr_dout[0], wr_dout[1], wr_dout[2]}, 32'h0301_02FF);
        check("t6 aborted", 32'(last_aborted), 32'd0);
`ifdef HS_HOST_CHECKSUM_EN
        check("t6 xfer_sum", 32'(xfer_sum), 32'h02);
`else
        check("t6 xfer_sum", 32'(xfer_sum), 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
